// File: rtl/pe_row_seq_ctrl_if.sv
// Control bundle between a PE-row sequencer and its tile source / result sink.
// The sequencer sits on the slave side; the driving environment on the master side.
interface pe_row_seq_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic [CNT_W-1:0] k_len;
  logic             feed_valid;
  logic             feed_ready;
  logic             zero_pad;
  logic             en_in;
  logic             en_psum;
  logic             clear_psum;
  logic             en_out;
  logic             output_eject_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, k_len, feed_valid, out_ready,
    input  feed_ready, zero_pad, en_in, en_psum, clear_psum, en_out,
           output_eject_ctrl, out_valid, busy, done
  );

  modport slave (
    input  start, k_len, feed_valid, out_ready,
    output feed_ready, zero_pad, en_in, en_psum, clear_psum, en_out,
           output_eject_ctrl, out_valid, busy, done
  );
endinterface

// File: rtl/pe_row_seq_ctrl.sv
// Tile sequencer for one row of output-stationary PEs sharing broadcast control:
// clear psums, stream k_len beats, flush the skew, settle, load and eject results.
module pe_row_seq_ctrl #(
  parameter int N_PE  = 16,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_row_seq_ctrl_if.slave     bus
);

  localparam int CW = $clog2(N_PE + 1);
  localparam logic [CW-1:0] NPE_C = CW'(N_PE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_FLUSH,
    S_SETTLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  // Per-state output flags, registered alongside the state.
  typedef struct packed {
    logic feed_ready;
    logic flush;
    logic clear;
    logic load;
    logic shift;
    logic busy;
    logic done;
  } flags_t;

  state_e           state_q, state_d;
  flags_t           flg_q, flg_d;
  logic [CNT_W-1:0] klen_q, klen_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CW-1:0]    flush_q, flush_d;
  logic [CW-1:0]    out_q, out_d;
  logic             en_psum_q, en_psum_d;
  logic             en_in;
  logic             accept;

  function automatic flags_t decode(input state_e s);
    flags_t f;
    f      = '0;
    f.busy = (s != S_IDLE);
    case (s)
      S_CLEAR:   f.clear      = 1'b1;
      S_COMPUTE: f.feed_ready = 1'b1;
      S_FLUSH:   f.flush      = 1'b1;
      S_LOAD:    f.load       = 1'b1;
      S_SHIFT:   f.shift      = 1'b1;
      S_DONE:    f.done       = 1'b1;
      default:   ;
    endcase
    return f;
  endfunction

  assign accept = flg_q.feed_ready & bus.feed_valid;
  assign en_in  = accept | flg_q.flush;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.k_len != '0) begin
            klen_d  = bus.k_len;
            beat_d  = '0;
            flush_d = '0;
            out_d   = '0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR:   state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_d == klen_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_d == NPE_C) state_d = S_SETTLE;
      end
      S_SETTLE:  state_d = S_LOAD;
      S_LOAD:    state_d = S_SHIFT;
      S_SHIFT: begin
        if (bus.out_ready) begin
          out_d = out_q + 1'b1;
          if (out_d == NPE_C) state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    flg_d = decode(state_d);
    // Psum update trails operand load by one cycle; suppressed right after a
    // clear and in every state where the PE arrays are not accumulating.
    en_psum_d = en_in & (state_q != S_CLEAR) &
                ((state_d == S_COMPUTE) | (state_d == S_FLUSH) | (state_d == S_SETTLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      flg_q     <= '0;
      klen_q    <= '0;
      beat_q    <= '0;
      flush_q   <= '0;
      out_q     <= '0;
      en_psum_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flg_q     <= flg_d;
      klen_q    <= klen_d;
      beat_q    <= beat_d;
      flush_q   <= flush_d;
      out_q     <= out_d;
      en_psum_q <= en_psum_d;
    end
  end

  assign bus.feed_ready        = flg_q.feed_ready;
  assign bus.zero_pad          = flg_q.flush;
  assign bus.en_in             = en_in;
  assign bus.en_psum           = en_psum_q;
  assign bus.clear_psum        = flg_q.clear;
  assign bus.en_out            = flg_q.load | (flg_q.shift & bus.out_ready);
  assign bus.output_eject_ctrl = flg_q.shift;
  assign bus.out_valid         = flg_q.shift;
  assign bus.busy              = flg_q.busy;
  assign bus.done              = flg_q.done;

endmodule

// File: tb/tb_pe_row_seq_ctrl.sv
// Directed bench for pe_row_seq_ctrl with N_PE=4: full-rate tile, throttled feed,
// sink stall, k_len=0, reset mid-tile and start filtering.
module tb_pe_row_seq_ctrl;
  localparam int NPE = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  pe_row_seq_ctrl_if #(.CNT_W(10)) bus ();

  pe_row_seq_ctrl #(.N_PE(NPE), .CNT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {feed_ready, zero_pad, en_in, en_psum, clear_psum, en_out, eject, out_valid, busy, done}
  logic [9:0] vec;
  assign vec = {bus.feed_ready, bus.zero_pad, bus.en_in, bus.en_psum, bus.clear_psum,
                bus.en_out, bus.output_eject_ctrl, bus.out_valid, bus.busy, bus.done};

  // Expected output vector c cycles after the start edge, feed_valid=1, out_ready=1.
  function automatic logic [9:0] golden(input int k, input int c);
    logic [9:0] v;
    v = '0;
    if (c < 1) v = '0;
    else if (k == 0) begin
      if (c == 1) v = 10'b0000000011;
    end
    else if (c == 1)               v = 10'b0000100010;
    else if (c <= k + 1)           v = (c == 2) ? 10'b1010000010 : 10'b1011000010;
    else if (c <= k + 1 + NPE)     v = 10'b0111000010;
    else if (c == k + 2 + NPE)     v = 10'b0001000010;
    else if (c == k + 3 + NPE)     v = 10'b0000010010;
    else if (c <= k + 3 + 2 * NPE) v = 10'b0000011110;
    else if (c == k + 4 + 2 * NPE) v = 10'b0000000011;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Advance to the next cycle and drive that cycle's inputs.
  task automatic step(input logic s, input logic fv, input logic rdy, input logic r);
    @(posedge clk);
    #1;
    bus.start      = s;
    bus.feed_valid = fv;
    bus.out_ready  = rdy;
    rst            = r;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    int beats, hs, cd;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.feed_valid = 1'b0;
    bus.out_ready = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_state", vec, 10'b0);

    // Full-rate tile, k_len=3
    bus.k_len = 10'd3;
    step(1, 1, 1, 0);
    chk("t1_c0_idle", vec, 10'b0);
    for (int c = 1; c <= 16; c++) begin
      step(0, 1, 1, 0);
      chk($sformatf("t1_c%0d", c), vec, golden(3, c));
    end

    // Throttled feed 1,0,1,0,1
    pat = 5'b10101;
    beats = 0;
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("t2_clear_no_ack", {8'b0, bus.feed_ready, bus.en_in}, 10'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, pat[i], 1, 0);
      chk($sformatf("t2_en_in_c%0d", i + 2), {9'b0, bus.en_in}, {9'b0, pat[i]});
      chk($sformatf("t2_en_psum_c%0d", i + 2), {9'b0, bus.en_psum},
          {9'b0, (i == 0) ? 1'b0 : pat[i-1]});
      if (bus.en_in && bus.feed_ready) beats++;
    end
    chk("t2_beats", 10'(beats), 10'd3);
    step(0, 0, 1, 0);
    chk("t2_c7_flush", {bus.feed_ready, bus.zero_pad, bus.en_in, bus.en_psum, 6'b0},
        10'b0111000000);
    cd = 8;
    while (cd <= 40) begin
      step(0, 0, 1, 0);
      if (bus.done) break;
      cd++;
    end
    chk("t2_done_cycle", 10'(cd), 10'd17);

    // Sink stall for 5 cycles after LOAD
    bus.k_len = 10'd3;
    hs = 0;
    step(1, 1, 1, 0);
    for (int c = 1; c <= 10; c++) step(0, 1, 1, 0);
    chk("t3_load", vec, golden(3, 10));
    for (int c = 11; c <= 15; c++) begin
      step(0, 1, 0, 0);
      chk($sformatf("t3_stall_c%0d", c), {bus.out_valid, bus.en_out, bus.output_eject_ctrl, 7'b0},
          10'b1010000000);
      if (bus.out_valid && bus.out_ready) hs++;
    end
    for (int c = 16; c <= 19; c++) begin
      step(0, 1, 1, 0);
      chk($sformatf("t3_shift_c%0d", c), {bus.out_valid, bus.en_out, bus.done, 7'b0},
          10'b1100000000);
      if (bus.out_valid && bus.out_ready) hs++;
    end
    chk("t3_handshakes", 10'(hs), 10'd4);
    step(0, 1, 1, 0);
    chk("t3_done", vec, 10'b0000000011);

    // k_len = 0
    bus.k_len = 10'd0;
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("t4_done", vec, 10'b0000000011);
    step(0, 1, 1, 0);
    chk("t4_idle", vec, 10'b0);

    // Reset mid-COMPUTE
    bus.k_len = 10'd5;
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("t5_compute", vec, golden(5, 3));
    step(0, 1, 1, 0);
    chk("t5_rst_compute", vec, 10'b0);
    step(0, 1, 1, 0);
    chk("t5_idle_after_rst", vec, 10'b0);
    // Reset mid-SHIFT
    bus.k_len = 10'd1;
    step(1, 1, 1, 0);
    for (int c = 1; c <= 9; c++) step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("t5_shift", vec, golden(1, 10));
    step(0, 1, 1, 0);
    chk("t5_rst_shift", vec, 10'b0);
    // Reset and start together
    bus.k_len = 10'd2;
    step(1, 1, 1, 1);
    step(0, 1, 1, 0);
    chk("t5_rst_wins", vec, 10'b0);
    step(1, 1, 1, 0);
    for (int c = 1; c <= 15; c++) begin
      step(0, 1, 1, 0);
      chk($sformatf("t5_k2_c%0d", c), vec, golden(2, c));
    end

    // Start during COMPUTE and DONE ignored; first IDLE cycle accepted
    bus.k_len = 10'd3;
    step(1, 1, 1, 0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 3)  bus.k_len = 10'd7;
      if (c == 15) bus.k_len = 10'd2;
      step((c == 3 || c == 15 || c == 16), 1, 1, 0);
      chk($sformatf("t6_c%0d", c), vec, golden(3, c));
    end
    for (int c = 1; c <= 15; c++) begin
      step(0, 1, 1, 0);
      chk($sformatf("t6_restart_c%0d", c), vec, golden(2, c));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
